// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable divider controller: sequences the divide counter and
// applies new ratios only at period boundaries so every ratio switch is glitch-free.
module clk_div_ctrl #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             tick,
  output logic             div_out,
  output logic             active,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  state_t           state;
  logic [CNT_W-1:0] cur_div;
  logic [CNT_W-1:0] pend_div;
  logic             accept;
  logic             legal;
  logic             terminal;

  assign accept   = cfg_valid && cfg_ready;
  assign legal    = cfg_div >= CNT_W'(2);
  assign terminal = cnt == (cur_div - CNT_W'(1));

  // Status outputs are decoded from registers only.
  assign cfg_ready = state != PEND;
  assign active    = state != IDLE;
  assign tick      = active && terminal;
  assign div_out   = active && (cnt < (cur_div >> 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_div  <= DIV_RST;
      pend_div <= DIV_RST;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= accept && !legal;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept && legal) cur_div <= cfg_div;
          if (enable) state <= RUN;
        end
        RUN: begin
          if (!enable) begin
            // A ratio accepted while stopping is kept rather than dropped.
            state <= IDLE;
            cnt   <= '0;
            if (accept && legal) cur_div <= cfg_div;
          end else if (terminal) begin
            cnt <= '0;
            if (accept && legal) cur_div <= cfg_div;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (accept && legal) begin
              pend_div <= cfg_div;
              state    <= PEND;
            end
          end
        end
        PEND: begin
          if (!enable) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_div <= pend_div;
          end else if (terminal) begin
            state   <= RUN;
            cnt     <= '0;
            cur_div <= pend_div;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios plus randomized traffic against a
// period-level reference model.
module tb_clk_div_ctrl;

  localparam int unsigned CNT_W = 8;
  localparam int DEF_DIV = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             tick;
  logic             div_out;
  logic             active;
  logic [CNT_W-1:0] cnt;

  int total = 0;
  int bad = 0;

  // Reference model: running flag, ratio, pending ratio (0 = none), position in period.
  bit m_run;
  int m_n;
  int m_pend;
  int m_pos;
  bit m_err;

  clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF_DIV)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_valid(cfg_valid),
    .cfg_div(cfg_div), .cfg_ready(cfg_ready), .cfg_err(cfg_err), .tick(tick),
    .div_out(div_out), .active(active), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit rst, input bit en, input bit v, input int d);
    bit acc;
    bit ok;
    acc = v && (m_pend == 0);
    ok  = acc && (d >= 2);
    if (rst) begin
      m_run = 0; m_n = DEF_DIV; m_pend = 0; m_pos = 0; m_err = 0;
    end else begin
      m_err = acc && !ok;
      if (!en) begin
        if (m_pend != 0) m_n = m_pend;
        else if (ok) m_n = d;
        m_pend = 0; m_run = 0; m_pos = 0;
      end else if (!m_run) begin
        if (ok) m_n = d;
        m_run = 1; m_pos = 0;
      end else if (m_pos == m_n - 1) begin
        m_pos = 0;
        if (m_pend != 0) begin
          m_n = m_pend; m_pend = 0;
        end else if (ok) m_n = d;
      end else begin
        m_pos++;
        if (ok) m_pend = d;
      end
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic drive(input bit rst, input bit en, input bit v, input int d);
    reset = rst; enable = en; cfg_valid = v; cfg_div = CNT_W'(d);
    @(posedge clk);
    #1;
    model_step(rst, en, v, d);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    total++;
    if ({active, tick, div_out, cfg_ready, cfg_err, cnt} !== {5'b00010, 8'd0}) begin
      bad++;
      $display("FAIL reset_state: got a=%b t=%b d=%b r=%b e=%b cnt=%0d want a=0 t=0 d=0 r=1 e=0 cnt=0",
               active, tick, div_out, cfg_ready, cfg_err, cnt);
    end
    // Default ratio 2 shows up as a two-cycle period.
    drive(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cnt !== CNT_W'(i % 2) || tick !== (i % 2 == 1)) begin
        bad++;
        $display("FAIL reset_default_div: cycle %0d cnt=%0d tick=%b want cnt=%0d tick=%b",
                 i, cnt, tick, i % 2, i % 2 == 1);
      end
      drive(0, 1, 0, 0);
    end
  endtask

  task automatic test_run4();
    do_reset();
    drive(0, 0, 1, 4);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (active !== 1'b1 || cnt !== CNT_W'(i % 4) || div_out !== (i % 4 < 2) ||
          tick !== (i % 4 == 3)) begin
        bad++;
        $display("FAIL run4: cycle %0d a=%b cnt=%0d d=%b t=%b want a=1 cnt=%0d d=%b t=%b",
                 i, active, cnt, div_out, tick, i % 4, i % 4 < 2, i % 4 == 3);
      end
      drive(0, 1, 0, 0);
    end
  endtask

  task automatic test_change();
    // Continues from test_run4 at cnt=0, N=4.
    drive(0, 1, 0, 0);
    drive(0, 1, 1, 3);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (cfg_ready !== 1'b0 || cnt !== CNT_W'(2 + i)) begin
        bad++;
        $display("FAIL change_pend: cycle %0d ready=%b cnt=%0d want ready=0 cnt=%0d",
                 i, cfg_ready, cnt, 2 + i);
      end
      drive(0, 1, 0, 0);
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (cfg_ready !== 1'b1 || cnt !== CNT_W'(i % 3) || div_out !== (i % 3 == 0)) begin
        bad++;
        $display("FAIL change_n3: cycle %0d ready=%b cnt=%0d d=%b want ready=1 cnt=%0d d=%b",
                 i, cfg_ready, cnt, div_out, i % 3, i % 3 == 0);
      end
      drive(0, 1, 0, 0);
    end
  endtask

  task automatic test_terminal_accept();
    do_reset();
    drive(0, 0, 1, 5);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0);
    total++;
    if (cnt !== CNT_W'(4) || tick !== 1'b1 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL term_pre: cnt=%0d tick=%b ready=%b want cnt=4 tick=1 ready=1",
               cnt, tick, cfg_ready);
    end
    drive(0, 1, 1, 2);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cnt !== CNT_W'(i % 2) || tick !== (i % 2 == 1) || cfg_ready !== 1'b1) begin
        bad++;
        $display("FAIL term_n2: cycle %0d cnt=%0d tick=%b ready=%b want cnt=%0d tick=%b ready=1",
                 i, cnt, tick, cfg_ready, i % 2, i % 2 == 1);
      end
      drive(0, 1, 0, 0);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(0, 0, 1, 4);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 1, 1);
    total++;
    if (cfg_err !== 1'b1 || cnt !== CNT_W'(2) || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL illegal_err: err=%b cnt=%0d ready=%b want err=1 cnt=2 ready=1",
               cfg_err, cnt, cfg_ready);
    end
    drive(0, 1, 0, 0);
    total++;
    if (cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL illegal_pulse: err=%b want 0", cfg_err);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (active !== 1'b1 || cnt !== CNT_W'((3 + i) % 4)) begin
        bad++;
        $display("FAIL illegal_period: cycle %0d a=%b cnt=%0d want a=1 cnt=%0d",
                 i, active, cnt, (3 + i) % 4);
      end
      drive(0, 1, 0, 0);
    end
  endtask

  task automatic test_drop_in_pend();
    do_reset();
    drive(0, 0, 1, 6);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 1, 8);
    total++;
    if (cnt !== CNT_W'(3) || cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL drop_pend: cnt=%0d ready=%b want cnt=3 ready=0", cnt, cfg_ready);
    end
    drive(0, 0, 0, 0);
    total++;
    if (active !== 1'b0 || cnt !== CNT_W'(0) || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL drop_idle: a=%b cnt=%0d ready=%b want a=0 cnt=0 ready=1",
               active, cnt, cfg_ready);
    end
    drive(0, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (cnt !== CNT_W'(i % 8) || div_out !== (i % 8 < 4) || tick !== (i % 8 == 7)) begin
        bad++;
        $display("FAIL drop_n8: cycle %0d cnt=%0d d=%b t=%b want cnt=%0d d=%b t=%b",
                 i, cnt, div_out, tick, i % 8, i % 8 < 4, i % 8 == 7);
      end
      drive(0, 1, 0, 0);
    end
  endtask

  task automatic test_reset_in_pend();
    do_reset();
    drive(0, 0, 1, 4);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 1, 7);
    drive(1, 1, 0, 0);
    total++;
    if (active !== 1'b0 || cnt !== CNT_W'(0) || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_pend: a=%b cnt=%0d ready=%b want a=0 cnt=0 ready=1",
               active, cnt, cfg_ready);
    end
    drive(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (cnt !== CNT_W'(i % 2) || tick !== (i % 2 == 1)) begin
        bad++;
        $display("FAIL rst_pend_n2: cycle %0d cnt=%0d tick=%b want cnt=%0d tick=%b",
                 i, cnt, tick, i % 2, i % 2 == 1);
      end
      drive(0, 1, 0, 0);
    end
  endtask

  task automatic test_random();
    logic [12:0] obs;
    logic [12:0] exp;
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      obs = {active, tick, div_out, cfg_ready, cfg_err, cnt};
      exp = {m_run, m_run && (m_pos == m_n - 1), m_run && (m_pos < m_n / 2),
             m_pend == 0, m_err, CNT_W'(m_pos)};
      total++;
      if (obs !== exp) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL random: cycle %0d got {a,t,d,r,e,cnt}=%b want %b", i, obs, exp);
      end
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 19) != 0,
            $urandom_range(0, 2) == 0, int'($urandom_range(0, 12)));
    end
  endtask

  initial begin
    m_run = 0; m_n = DEF_DIV; m_pend = 0; m_pos = 0; m_err = 0;
    test_reset();
    test_run4();
    test_change();
    test_terminal_accept();
    test_illegal();
    test_drop_in_pend();
    test_reset_in_pend();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
